// File: rtl/acorn_pkg.sv
// ACORN-128 shared definitions: state width, tap positions, boolean helpers and
// the single-step state update used by the unrolled step chain.
package acorn_pkg;

  localparam int ACORN_STATE_W = 293;

  localparam int T_LFSR0 = 289;
  localparam int T_LFSR1 = 230;
  localparam int T_LFSR2 = 193;
  localparam int T_LFSR3 = 154;
  localparam int T_LFSR4 = 107;
  localparam int T_LFSR5 = 61;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acorn_fsm_e;

  typedef struct packed {
    logic [ACORN_STATE_W-1:0] state;
    logic                     ks;
    logic                     out_bit;
  } acorn_step_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic acorn_step_t acorn_step(input logic [ACORN_STATE_W-1:0] s,
                                             input logic ca, input logic cb,
                                             input logic dec, input logic in_bit);
    acorn_step_t              r;
    logic [ACORN_STATE_W-1:0] t;
    logic                     ks;
    logic                     m;
    logic                     f;
    // Linear feedback uses only pre-step values; keystream and f see the result.
    t          = s;
    t[T_LFSR0] = s[289] ^ s[235] ^ s[230];
    t[T_LFSR1] = s[230] ^ s[196] ^ s[193];
    t[T_LFSR2] = s[193] ^ s[160] ^ s[154];
    t[T_LFSR3] = s[154] ^ s[111] ^ s[107];
    t[T_LFSR4] = s[107] ^ s[66]  ^ s[61];
    t[T_LFSR5] = s[61]  ^ s[23]  ^ s[0];
    ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    m  = dec ? (in_bit ^ ks) : in_bit;
    f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    r.state   = {f ^ m, t[ACORN_STATE_W-1:1]};
    r.ks      = ks;
    r.out_bit = in_bit ^ ks;
    return r;
  endfunction

endpackage

// File: rtl/acorn_step_unroll.sv
// Combinational chain of STEPS ACORN steps; bit 0 of the data/keystream vectors
// belongs to the first step applied.
module acorn_step_unroll
  import acorn_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic [ACORN_STATE_W-1:0] state_in,
  input  logic                     ca,
  input  logic                     cb,
  input  logic                     dec,
  input  logic [STEPS-1:0]         data_in,
  output logic [ACORN_STATE_W-1:0] state_out,
  output logic [STEPS-1:0]         ks,
  output logic [STEPS-1:0]         data_out
);

  logic [ACORN_STATE_W-1:0] st;
  acorn_step_t              step_r;

  always_comb begin
    st       = state_in;
    step_r   = '0;
    ks       = '0;
    data_out = '0;
    for (int i = 0; i < STEPS; i++) begin
      step_r      = acorn_step(st, ca, cb, dec, data_in[i]);
      st          = step_r.state;
      ks[i]       = step_r.ks;
      data_out[i] = step_r.out_bit;
    end
    state_out = st;
  end

endmodule

// File: rtl/acorn_state_update_par.sv
// ACORN-128 state-update engine: STEPS cipher steps per accepted beat, burst
// command control, single output register with valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for a burst command; input not accepted
//   RUN   | accepting beats until the burst counter reaches zero
module acorn_state_update_par
  import acorn_pkg::*;
#(
  parameter int STEPS = 1,
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [ACORN_STATE_W-1:0] state_in,
  input  logic                     cmd_valid,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     cmd_ca,
  input  logic                     cmd_cb,
  input  logic                     cmd_dec,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STEPS-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [STEPS-1:0]         out_data,
  output logic [STEPS-1:0]         out_ks,
  output logic                     busy,
  output logic                     done,
  output logic [ACORN_STATE_W-1:0] state_out
);

  acorn_fsm_e               fsm_q;
  logic [ACORN_STATE_W-1:0] state_q;
  logic [LEN_W-1:0]         cnt_q;
  logic                     ca_q;
  logic                     cb_q;
  logic                     dec_q;
  logic [ACORN_STATE_W-1:0] state_nxt;
  logic [STEPS-1:0]         ks_nxt;
  logic [STEPS-1:0]         data_nxt;
  logic                     accept;

  acorn_step_unroll #(.STEPS(STEPS)) u_unroll (
    .state_in  (state_q),
    .ca        (ca_q),
    .cb        (cb_q),
    .dec       (dec_q),
    .data_in   (in_data),
    .state_out (state_nxt),
    .ks        (ks_nxt),
    .data_out  (data_nxt)
  );

  assign in_ready  = (fsm_q == ST_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !load_en;
  assign busy      = (fsm_q == ST_RUN);
  assign state_out = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      cnt_q     <= '0;
      ca_q      <= 1'b0;
      cb_q      <= 1'b0;
      dec_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ks    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_en) begin
        // Load aborts any burst silently: no done, pending output dropped.
        state_q   <= state_in;
        fsm_q     <= ST_IDLE;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          out_valid <= 1'b1;
          out_data  <= data_nxt;
          out_ks    <= ks_nxt;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        case (fsm_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              if (cmd_len != '0) begin
                fsm_q <= ST_RUN;
                cnt_q <= cmd_len;
                ca_q  <= cmd_ca;
                cb_q  <= cmd_cb;
                dec_q <= cmd_dec;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (accept) begin
              state_q <= state_nxt;
              cnt_q   <= cnt_q - 1'b1;
              if (cnt_q == LEN_W'(1)) begin
                fsm_q <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: fsm_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acorn_state_update_par.sv
// Directed bench: three engine widths (1, 8, 32 steps) driven in lockstep and
// checked against a bit-serial reference of the ACORN step.
module tb_acorn_state_update_par;

  localparam int LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, load_en, cmd_valid, cmd_ca, cmd_cb, cmd_dec, in_valid, out_ready;
  logic [292:0] state_in;
  logic [LW-1:0] len1, len8, len32;
  logic [0:0]   in1, od1, ks1;
  logic [7:0]   in8, od8, ks8;
  logic [31:0]  in32, od32, ks32;
  logic         ir1, ov1, busy1, done1;
  logic         ir8, ov8, busy8, done8;
  logic         ir32, ov32, busy32, done32;
  logic [292:0] so1, so8, so32;

  logic [511:0] msg;
  logic [8:0]   b1, b8, b32, c1, c8, c32;
  logic [511:0] cks1, cks8, cks32, cod1, cod8, cod32;
  int           dn1, dn8, dn32;
  logic         clr;
  int           n_chk = 0;
  int           n_bad = 0;

  assign in1  = msg[b1 +: 1];
  assign in8  = msg[b8 +: 8];
  assign in32 = msg[b32 +: 32];

  acorn_state_update_par #(.STEPS(1), .LEN_W(LW)) u1 (
    .clk(clk), .rst(rst), .load_en(load_en), .state_in(state_in), .cmd_valid(cmd_valid),
    .cmd_len(len1), .cmd_ca(cmd_ca), .cmd_cb(cmd_cb), .cmd_dec(cmd_dec), .in_valid(in_valid),
    .in_ready(ir1), .in_data(in1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ks(ks1), .busy(busy1), .done(done1), .state_out(so1));

  acorn_state_update_par #(.STEPS(8), .LEN_W(LW)) u8 (
    .clk(clk), .rst(rst), .load_en(load_en), .state_in(state_in), .cmd_valid(cmd_valid),
    .cmd_len(len8), .cmd_ca(cmd_ca), .cmd_cb(cmd_cb), .cmd_dec(cmd_dec), .in_valid(in_valid),
    .in_ready(ir8), .in_data(in8), .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
    .out_ks(ks8), .busy(busy8), .done(done8), .state_out(so8));

  acorn_state_update_par #(.STEPS(32), .LEN_W(LW)) u32 (
    .clk(clk), .rst(rst), .load_en(load_en), .state_in(state_in), .cmd_valid(cmd_valid),
    .cmd_len(len32), .cmd_ca(cmd_ca), .cmd_cb(cmd_cb), .cmd_dec(cmd_dec), .in_valid(in_valid),
    .in_ready(ir32), .in_data(in32), .out_valid(ov32), .out_ready(out_ready), .out_data(od32),
    .out_ks(ks32), .busy(busy32), .done(done32), .state_out(so32));

  // Beat, output and done bookkeeping per instance.
  always @(posedge clk) begin
    if (clr) begin
      b1 <= '0; b8 <= '0; b32 <= '0; c1 <= '0; c8 <= '0; c32 <= '0;
      cks1 <= '0; cks8 <= '0; cks32 <= '0; cod1 <= '0; cod8 <= '0; cod32 <= '0;
      dn1 <= 0; dn8 <= 0; dn32 <= 0;
    end else begin
      if (in_valid && ir1  && !load_en) b1  <= b1  + 9'd1;
      if (in_valid && ir8  && !load_en) b8  <= b8  + 9'd8;
      if (in_valid && ir32 && !load_en) b32 <= b32 + 9'd32;
      if (ov1 && out_ready) begin
        cks1[c1 +: 1] <= ks1; cod1[c1 +: 1] <= od1; c1 <= c1 + 9'd1;
      end
      if (ov8 && out_ready) begin
        cks8[c8 +: 8] <= ks8; cod8[c8 +: 8] <= od8; c8 <= c8 + 9'd8;
      end
      if (ov32 && out_ready) begin
        cks32[c32 +: 32] <= ks32; cod32[c32 +: 32] <= od32; c32 <= c32 + 9'd32;
      end
      if (done1)  dn1  <= dn1 + 1;
      if (done8)  dn8  <= dn8 + 1;
      if (done32) dn32 <= dn32 + 1;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference over msg[0 +: nbits].
  task automatic model_run(input logic [292:0] s0, input int nbits, input logic ca,
                           input logic cb, input logic dec, output logic [292:0] sf,
                           output logic [511:0] kv, output logic [511:0] ov);
    logic [292:0] s, t;
    logic k, m, f, mj_ks, mj_f;
    s  = s0;
    kv = '0;
    ov = '0;
    for (int i = 0; i < nbits; i++) begin
      t      = s;
      t[289] = s[289] ^ s[235] ^ s[230];
      t[230] = s[230] ^ s[196] ^ s[193];
      t[193] = s[193] ^ s[160] ^ s[154];
      t[154] = s[154] ^ s[111] ^ s[107];
      t[107] = s[107] ^ s[66]  ^ s[61];
      t[61]  = s[61]  ^ s[23]  ^ s[0];
      mj_ks  = (t[235] & t[61]) | (t[235] & t[193]) | (t[61] & t[193]);
      k      = t[12] ^ t[154] ^ mj_ks ^ (t[230] ? t[111] : t[66]);
      m      = dec ? (msg[i] ^ k) : msg[i];
      mj_f   = (t[244] & t[23]) | (t[244] & t[160]) | (t[23] & t[160]);
      f      = t[0] ^ ~t[107] ^ mj_f ^ (ca & t[196]) ^ (cb & k);
      s      = {f ^ m, t[292:1]};
      kv[i]  = k;
      ov[i]  = msg[i] ^ k;
    end
    sf = s;
  endtask

  task automatic start(input logic [292:0] s, input int l1, input int l8, input int l32,
                       input logic ca, input logic cb, input logic dec);
    @(negedge clk);
    clr = 1'b1; load_en = 1'b1; state_in = s;
    @(negedge clk);
    clr = 1'b0; load_en = 1'b0; cmd_valid = 1'b1;
    len1 = LW'(l1); len8 = LW'(l8); len32 = LW'(l32);
    cmd_ca = ca; cmd_cb = cb; cmd_dec = dec; in_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (!busy1 && !busy8 && !busy32 && !ov1 && !ov8 && !ov32) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_idle"}, {511'b0, ok}, 512'd1);
    @(negedge clk);
  endtask

  function automatic logic [292:0] rand_state();
    logic [292:0] s;
    for (int i = 0; i < 10; i++) s[i*29 +: 29] = 29'($urandom);
    s[292:290] = 3'($urandom);
    return s;
  endfunction

  task automatic rand_msg(input int nbits);
    msg = '0;
    for (int i = 0; i < nbits; i++) msg[i] = 1'($urandom);
  endtask

  logic [292:0] s_a, s_b, sf_m, sf_enc;
  logic [511:0] kv_m, ov_m, pt, ct;

  initial begin
    rst = 1'b1; load_en = 1'b0; state_in = '0; cmd_valid = 1'b0; cmd_ca = 1'b0;
    cmd_cb = 1'b0; cmd_dec = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b1;
    len1 = '0; len8 = '0; len32 = '0; msg = '0;
    repeat (3) @(negedge clk);
    check("rst_state8", {219'b0, so8}, 512'd0);
    check("rst_ctl8", {492'b0, ir8, ov8, busy8, done8, od8, ks8}, 512'd0);
    rst = 1'b0; clr = 1'b0;

    // Zero state, one step: keystream 0, f = ~0 = 1 shifted into bit 292.
    msg = '0;
    start('0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    wait_idle("smoke", 20);
    check("smoke_ks1", cks1, 512'd0);
    check("smoke_out1", cod1, 512'd0);
    check("smoke_state1", {219'b0, so1}, {219'b0, 1'b1, 292'b0});
    check("smoke_done1", 512'(dn1), 512'd1);
    check("len0_done8", 512'(dn8), 512'd1);

    // 320 steps through all three widths.
    s_a = rand_state();
    rand_msg(320);
    start(s_a, 320, 40, 10, 1'b1, 1'b1, 1'b0);
    wait_idle("eq", 500);
    model_run(s_a, 320, 1'b1, 1'b1, 1'b0, sf_m, kv_m, ov_m);
    check("eq_state1", {219'b0, so1}, {219'b0, sf_m});
    check("eq_state8", {219'b0, so8}, {219'b0, sf_m});
    check("eq_state32", {219'b0, so32}, {219'b0, sf_m});
    check("eq_ks1", cks1, kv_m);
    check("eq_ks8", cks8, kv_m);
    check("eq_ks32", cks32, kv_m);
    check("eq_out8", cod8, ov_m);
    check("eq_done", 512'(dn1 + dn8 + dn32), 512'd3);

    // Encrypt then decrypt from the same state.
    s_b = rand_state();
    rand_msg(64);
    pt = msg;
    start(s_b, 64, 8, 2, 1'b1, 1'b0, 1'b0);
    wait_idle("enc", 120);
    model_run(s_b, 64, 1'b1, 1'b0, 1'b0, sf_enc, kv_m, ov_m);
    check("enc_ct8", cod8, ov_m);
    check("enc_state8", {219'b0, so8}, {219'b0, sf_enc});
    ct = '0;
    ct[63:0] = ov_m[63:0];
    msg = ct;
    start(s_b, 64, 8, 2, 1'b1, 1'b0, 1'b1);
    wait_idle("dec", 120);
    check("dec_pt1", cod1, pt);
    check("dec_pt8", cod8, pt);
    check("dec_pt32", cod32, pt);
    check("dec_state8", {219'b0, so8}, {219'b0, sf_enc});
    check("dec_state32", {219'b0, so32}, {219'b0, sf_enc});

    // Output backpressure for 5 cycles mid-burst.
    s_a = rand_state();
    rand_msg(96);
    start(s_a, 96, 12, 3, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    begin
      logic [7:0] held;
      held = od8;
      for (int i = 0; i < 5; i++) begin
        check("bp_in_ready8", {511'b0, ir8}, 512'd0);
        check("bp_valid8", {511'b0, ov8}, 512'd1);
        check("bp_data8", {504'b0, od8}, {504'b0, held});
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    wait_idle("bp", 200);
    model_run(s_a, 96, 1'b1, 1'b0, 1'b0, sf_m, kv_m, ov_m);
    check("bp_ks8", cks8, kv_m);
    check("bp_ks1", cks1, kv_m);
    check("bp_state8", {219'b0, so8}, {219'b0, sf_m});
    check("bp_beats8", {503'b0, b8}, 512'd96);
    check("bp_done8", 512'(dn8), 512'd1);

    // Load during beat 3 of 10 aborts the burst.
    s_a = rand_state();
    s_b = rand_state();
    rand_msg(80);
    start(s_a, 80, 10, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    load_en = 1'b1; state_in = s_b;
    @(negedge clk);
    load_en = 1'b0;
    check("ld_busy8", {509'b0, busy8, ir8, ov8}, 512'd0);
    check("ld_state8", {219'b0, so8}, {219'b0, s_b});
    check("ld_beats8", {503'b0, b8}, 512'd16);
    repeat (4) @(negedge clk);
    check("ld_nodone8", 512'(dn8), 512'd0);
    check("ld_busy1", {511'b0, busy1}, 512'd0);

    // Zero-length command.
    s_a = rand_state();
    start(s_a, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("len0_pulse8", {510'b0, done8, busy8}, {510'b0, 2'b10});
    @(negedge clk);
    check("len0_end8", {509'b0, done8, busy8, ir8}, 512'd0);
    repeat (3) @(negedge clk);
    check("len0_count8", 512'(dn8), 512'd1);
    check("len0_beats8", {503'b0, b8}, 512'd0);
    check("len0_state8", {219'b0, so8}, {219'b0, s_a});

    // Reset in the middle of a burst.
    rand_msg(80);
    start(rand_state(), 80, 10, 2, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state8", {219'b0, so8}, 512'd0);
    check("rst_mid_ctl8", {492'b0, ir8, ov8, busy8, done8, od8, ks8}, 512'd0);
    check("rst_mid_ctl32", {444'b0, ir32, ov32, busy32, done32, od32, ks32}, 512'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
